// File: rtl/issue_ctrl.sv
// issue_ctrl: circular instruction buffer feeding a two-slot dispatch register.
// Pops one or two entries per cycle as the pair-check result allows.
`ifndef SINGLE_ISSUE
`define SINGLE_ISSUE 1'b0
`endif
`ifndef DUAL_ISSUE
`define DUAL_ISSUE 1'b1
`endif

module issue_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [1:0]                 fetch_valid,
  input  logic [31:0]                fetch_inst1,
  input  logic [31:0]                fetch_inst2,
  input  logic [31:0]                fetch_pc1,
  input  logic [31:0]                fetch_pc2,
  output logic                       fetch_ready,
  output logic [31:0]                chk_inst1,
  output logic [31:0]                chk_inst2,
  input  logic                       issue_mode,
  output logic [1:0]                 id_valid,
  output logic [31:0]                id_inst1,
  output logic [31:0]                id_inst2,
  output logic [31:0]                id_pc1,
  output logic [31:0]                id_pc2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [CW-1:0] count_q;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          pop_hold;
  logic          pop_one;
  logic          pop_two;

  assign count       = count_q;
  assign head_p1     = head + AW'(1);
  assign tail_p1     = tail + AW'(1);
  assign fetch_ready = (count_q <= CW'(DEPTH - 2));

  assign chk_inst1 = (count_q >= CW'(1)) ? inst_mem[head] : 32'h0;
  assign chk_inst2 = (count_q >= CW'(2)) ? inst_mem[head_p1] : 32'h0;

  always_comb begin
    push_n = 2'd0;
    if (fetch_ready && !flush) begin
      unique case (fetch_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

  // Exclusive pop conditions so the one-hot decode below never overlaps.
  assign pop_hold = stall || flush || (count_q == '0);
  assign pop_one  = !pop_hold &&
                    ((count_q == CW'(1)) || (issue_mode == `SINGLE_ISSUE));
  assign pop_two  = !pop_hold && !pop_one;

  always_comb begin
    pop_n = 2'd0;
    unique case (1'b1)
      pop_one: pop_n = 2'd1;
      pop_two: pop_n = 2'd2;
      default: pop_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push_n != 2'd0) begin
      inst_mem[tail] <= fetch_inst1;
      pc_mem[tail]   <= fetch_pc1;
    end
    if (!rst && push_n == 2'd2) begin
      inst_mem[tail_p1] <= fetch_inst2;
      pc_mem[tail_p1]   <= fetch_pc2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      id_valid <= 2'b00;
      id_inst1 <= 32'h0;
      id_inst2 <= 32'h0;
      id_pc1   <= 32'h0;
      id_pc2   <= 32'h0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      id_valid <= 2'b00;
      id_inst2 <= 32'h0;
    end else begin
      head    <= head + AW'(pop_n);
      tail    <= tail + AW'(push_n);
      count_q <= count_q + CW'(push_n) - CW'(pop_n);
      if (!stall) begin
        unique case (pop_n)
          2'd1: begin
            id_valid <= 2'b01;
            id_inst1 <= inst_mem[head];
            id_pc1   <= pc_mem[head];
            id_inst2 <= 32'h0;
            id_pc2   <= 32'h0;
          end
          2'd2: begin
            id_valid <= 2'b11;
            id_inst1 <= inst_mem[head];
            id_pc1   <= pc_mem[head];
            id_inst2 <= inst_mem[head_p1];
            id_pc2   <= pc_mem[head_p1];
          end
          default: begin
            id_valid <= 2'b00;
            id_inst2 <= 32'h0;
          end
        endcase
      end
    end
  end

endmodule
